// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin one-hot arbiter: FSM state
// encoding and the default sizing constants used by the top level.
package arb_pkg;

   // Arbiter FSM states: IDLE searches for the next requester, GRANT holds it.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Default number of requesters (power of two, 2..16).
   localparam int DEF_NUM_REQ  = 16;
   // Default width of the binary grant index, log2(DEF_NUM_REQ).
   localparam int DEF_IDX_W    = 4;
   // Default maximum number of GRANT cycles before a forced release.
   localparam int DEF_MAX_HOLD = 15;

endpackage : arb_pkg

// File: rtl/bintoonehotenc.sv
// Binary-to-one-hot encoder: output bit k is set when bin_i equals k.
// Purely combinational; gating with a valid flag is left to the caller.
module bintoonehotenc #(
   parameter int bin_width    = 4,
   parameter int onehot_width = 16
) (
   input  logic [bin_width-1:0]    bin_i,
   output logic [onehot_width-1:0] onehot_o
);

   // One comparator per output bit.
   for (genvar gi = 0; gi < onehot_width; gi++) begin : g_dec
      assign onehot_o[gi] = (bin_i == bin_width'(gi));
   end

endmodule : bintoonehotenc

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered binary grant and combinational
// one-hot grant. The grant is held until the grantee signals done_i or
// drops its request; one idle cycle always separates two grants.
// Optional feature: define ARB_TIMEOUT_EN to bound every grant to
// MAX_HOLD cycles, with a one-cycle timeout_o pulse on forced release.
module rr_onehot_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int IDX_W    = DEF_IDX_W,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               done_i,
   output logic               gnt_valid_o,
   output logic [IDX_W-1:0]   gnt_bin_o,
   output logic [NUM_REQ-1:0] gnt_onehot_o,
   output logic               timeout_o
);

   arb_state_e         state_q,   state_d;
   logic [IDX_W-1:0]   gnt_bin_q, gnt_bin_d;
   logic [IDX_W-1:0]   ptr_q,     ptr_d;

   logic               search_hit;
   logic [IDX_W-1:0]   search_idx;
   logic               release_evt;
   logic [NUM_REQ-1:0] dec_onehot;

`ifdef ARB_TIMEOUT_EN
   localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

   logic [HOLD_W-1:0]  hold_q,    hold_d;
   logic               timeout_q, timeout_d;
   logic               hold_expired;

   // The current GRANT cycle is the MAX_HOLD-th one.
   assign hold_expired = (hold_q == HOLD_W'(MAX_HOLD - 1));
`endif

   // Rotating priority search: first set request strictly above ptr,
   // wrapping round so that ptr itself is considered last. The loop runs
   // from the farthest offset down so the nearest hit wins.
   always_comb begin
      logic [IDX_W-1:0] cand;
      search_hit = 1'b0;
      search_idx = '0;
      cand       = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = ptr_q + IDX_W'(i);
         if (req_i[cand]) begin
            search_hit = 1'b1;
            search_idx = cand;
         end
      end
   end

   // A grant ends when the grantee says so or stops requesting.
   assign release_evt = done_i | ~req_i[gnt_bin_q];

   // Next-state logic for the IDLE/GRANT FSM and its datapath registers.
   always_comb begin
      state_d   = state_q;
      gnt_bin_d = gnt_bin_q;
      ptr_d     = ptr_q;
`ifdef ARB_TIMEOUT_EN
      hold_d    = hold_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (search_hit) begin
               state_d   = GRANT;
               gnt_bin_d = search_idx;
               ptr_d     = search_idx;
`ifdef ARB_TIMEOUT_EN
               hold_d    = '0;
`endif
            end
         end
         GRANT: begin
            if (release_evt) begin
               // Normal release wins over a coincident timeout.
               state_d   = IDLE;
               gnt_bin_d = '0;
`ifdef ARB_TIMEOUT_EN
            end else if (hold_expired) begin
               state_d   = IDLE;
               gnt_bin_d = '0;
               timeout_d = 1'b1;
            end else begin
               hold_d    = hold_q + HOLD_W'(1);
`endif
            end
         end
         default: begin
            state_d   = IDLE;
            gnt_bin_d = '0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   // ptr resets to the top requester so the first search starts at 0.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         gnt_bin_q <= '0;
         ptr_q     <= IDX_W'(NUM_REQ - 1);
      end else begin
         state_q   <= state_d;
         gnt_bin_q <= gnt_bin_d;
         ptr_q     <= ptr_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Hold counter and timeout pulse; reset never produces a pulse.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

   assign gnt_valid_o = (state_q == GRANT);
   assign gnt_bin_o   = gnt_bin_q;

   bintoonehotenc #(
      .bin_width    (IDX_W),
      .onehot_width (NUM_REQ)
   ) u_dec (
      .bin_i    (gnt_bin_q),
      .onehot_o (dec_onehot)
   );

   assign gnt_onehot_o = dec_onehot & {NUM_REQ{gnt_valid_o}};

endmodule : rr_onehot_arbiter

// File: doc/rr_onehot_arbiter.md
RR_ONEHOT_ARBITER -- requirements
Module: rr_onehot_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 16, number of requesters (power of two, 2..16).
REQ-002 SHALL have parameter IDX_W, default 4, width of binary grant index, equal to log2(NUM_REQ).
REQ-003 SHALL have parameter MAX_HOLD, default 15, maximum grant cycles before forced release (used only with ARB_TIMEOUT_EN).
REQ-004 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n_i  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port req_i  input  NUM_REQ  request vector, bit k high means requester k wants the resource.
REQ-007 SHALL have port done_i  input  1  current grantee releases the resource this cycle.
REQ-008 SHALL have port gnt_valid_o  output  1  a grant is active.
REQ-009 SHALL have port gnt_bin_o  output  IDX_W  binary index of current grantee.
REQ-010 SHALL have port gnt_onehot_o  output  NUM_REQ  one-hot grant, bit gnt_bin_o set when gnt_valid_o is high, all zero otherwise.
REQ-011 SHALL have port timeout_o  output  1  one-cycle pulse when a grant is forcibly ended.

Function
REQ-012 SHALL implement FSM states IDLE and GRANT.
REQ-013 IDLE: if any req_i bit is high, SHALL select the first set bit searching upward from ptr+1 with wrap-around modulo NUM_REQ, register it into gnt_bin_o, set ptr to it, and enter GRANT.
REQ-014 Grant latency SHALL be exactly one cycle: req_i sampled in IDLE at edge N gives gnt_valid_o high after edge N.
REQ-015 GRANT: gnt_valid_o SHALL stay high and gnt_bin_o stable until a release event.
REQ-016 Release events SHALL be done_i high, or req_i[gnt_bin_o] low (requester drop); either SHALL return the FSM to IDLE at the next edge.
REQ-017 After a release, gnt_valid_o SHALL be low for exactly one cycle (IDLE) before any new grant.
REQ-018 With only the current grantee requesting after release, it SHALL be granted again (wrap search reaches itself last).
REQ-019 Changes to req_i bits other than the grantee's during GRANT SHALL have no effect until IDLE.
REQ-020 gnt_onehot_o SHALL be derived combinationally from registered gnt_bin_o gated by gnt_valid_o (no extra latency).
REQ-021 No request in IDLE: SHALL remain in IDLE, outputs zero, ptr unchanged.

Reset
REQ-022 On rst_n_i low at a rising edge: state SHALL be IDLE, gnt_valid_o 0, gnt_bin_o 0, gnt_onehot_o 0, timeout_o 0, hold counter 0, ptr NUM_REQ-1 (first search starts at requester 0).
REQ-023 Reset asserted during GRANT SHALL abort the grant at that edge with no timeout_o pulse.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN defined: a hold counter SHALL clear on entering GRANT and increment every GRANT cycle; when it reaches MAX_HOLD with no release, FSM SHALL go to IDLE and pulse timeout_o high for one cycle coincident with gnt_valid_o falling.
REQ-025 Simultaneous done_i and timeout condition SHALL be treated as normal release (no timeout_o pulse).
REQ-026 Macro ARB_TIMEOUT_EN undefined: no counter SHALL be built, timeout_o SHALL be tied 0, grants unbounded.

Structure
REQ-027 Shared package arb_pkg SHALL hold FSM state encoding (IDLE=0, GRANT=1) and default NUM_REQ/IDX_W/MAX_HOLD constants.
REQ-028 The binary-to-one-hot conversion SHALL be a sub-module instance of bintoonehotenc (bin_width=IDX_W, onehot_width=NUM_REQ).

Verification
REQ-029 Reset, req_i=16'h0001 -> after 1 edge gnt_valid_o=1, gnt_bin_o=0, gnt_onehot_o=16'h0001.
REQ-030 req_i=16'h8421 held, done_i pulsed once per grant -> grant order 0,5,10,15,0 with one low cycle between grants.
REQ-031 Grant to 3 with req_i=16'h0018, deassert bit 3 -> next edge IDLE, following edge grant to 4.
REQ-032 req_i=16'h0004 only, done_i pulsed -> 2 regranted after one idle cycle.
REQ-033 ARB_TIMEOUT_EN, MAX_HOLD=15, req_i=16'h0003, no done_i -> grantee 0 released after 15 GRANT cycles, timeout_o pulses once, then grant 1.
REQ-034 rst_n_i low mid-GRANT at index 7 -> outputs zero next edge, timeout_o stays 0, next grant searches from 0.
